// File: rtl/shift_pkg.sv
// Shared types, widths and the bit-reverse helper for the shift-op sequencer.
package shift_pkg;

  localparam int W     = 32;
  localparam int AMT_W = 5;

  typedef enum logic [2:0] {
    OP_LSL = 3'd0,
    OP_LSR = 3'd1,
    OP_ASR = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS_A = 2'd1,
    PASS_B = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  function automatic logic [W-1:0] rev32(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i] = x[W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_left_core.sv
// Combinational 32-bit zero-fill left barrel shifter, five mux stages (1,2,4,8,16).
module shift_left_core
  import shift_pkg::*;
(
  input  logic [W-1:0]     din,
  input  logic [AMT_W-1:0] amt,
  output logic [W-1:0]     dout
);

  logic [W-1:0] st1_s, st2_s, st4_s, st8_s;

  // Log-depth shift stages, each conditionally shifting by a power of two.
  always_comb begin
    st1_s = amt[0] ? {din[W-2:0],    1'b0}  : din;
    st2_s = amt[1] ? {st1_s[W-3:0],  2'b0}  : st1_s;
    st4_s = amt[2] ? {st2_s[W-5:0],  4'b0}  : st2_s;
    st8_s = amt[3] ? {st4_s[W-9:0],  8'b0}  : st4_s;
    dout  = amt[4] ? {st8_s[W-17:0], 16'b0} : st8_s;
  end

endmodule

// File: rtl/shift_op_sequencer.sv
// Runs LSL/LSR/ASR/ROL/ROR over one shared left shifter in one or two passes.
// Optional carry output is enabled by defining SHIFT_CARRY_EN.
module shift_op_sequencer
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [W-1:0]     in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
`ifdef SHIFT_CARRY_EN
  output logic             out_carry,
`endif
  output logic             out_err
);

  seq_state_t       state_r;
  logic [2:0]       op_r;
  logic [W-1:0]     data_r;
  logic [AMT_W-1:0] amt_r;
  logic [W-1:0]     partial_r;

  logic [AMT_W-1:0] amt_inv_s;
  logic [W-1:0]     sh_in_s;
  logic [AMT_W-1:0] sh_amt_s;
  logic [W-1:0]     sh_out_s;
  logic [W-1:0]     pass_a_res_s;
  logic [W-1:0]     pass_b_res_s;
  logic             two_pass_s;
  logic             err_s;

  assign amt_inv_s  = 5'd0 - amt_r;
  assign err_s      = (op_r > 3'd4);
  assign two_pass_s = (amt_r != 5'd0) &&
                      ((op_r == OP_ASR) || (op_r == OP_ROL) || (op_r == OP_ROR));

  // Shifter input mux: right shifts go through the left shifter bit-reversed.
  always_comb begin
    sh_in_s  = data_r;
    sh_amt_s = amt_r;
    if (state_r == PASS_B) begin
      case (op_r)
        OP_ASR:  begin sh_in_s = {W{1'b1}};     sh_amt_s = amt_r;     end
        OP_ROL:  begin sh_in_s = rev32(data_r); sh_amt_s = amt_inv_s; end
        OP_ROR:  begin sh_in_s = rev32(data_r); sh_amt_s = amt_r;     end
        default: begin sh_in_s = data_r;        sh_amt_s = amt_r;     end
      endcase
    end else begin
      case (op_r)
        OP_LSR,
        OP_ASR:  begin sh_in_s = rev32(data_r); sh_amt_s = amt_r;     end
        OP_ROR:  begin sh_in_s = data_r;        sh_amt_s = amt_inv_s; end
        default: begin sh_in_s = data_r;        sh_amt_s = amt_r;     end
      endcase
    end
  end

  shift_left_core u_core (
    .din  (sh_in_s),
    .amt  (sh_amt_s),
    .dout (sh_out_s)
  );

  // Per-pass result shaping; illegal opcodes collapse to zero.
  always_comb begin
    case (op_r)
      OP_LSL, OP_ROL, OP_ROR: pass_a_res_s = sh_out_s;
      OP_LSR, OP_ASR:         pass_a_res_s = rev32(sh_out_s);
      default:                pass_a_res_s = {W{1'b0}};
    endcase
    case (op_r)
      OP_ASR:         pass_b_res_s = partial_r | (data_r[W-1] ? ~rev32(sh_out_s) : {W{1'b0}});
      OP_ROL, OP_ROR: pass_b_res_s = partial_r | rev32(sh_out_s);
      default:        pass_b_res_s = partial_r;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  logic [AMT_W-1:0] idx_lo_s;
  logic             carry_s;

  assign idx_lo_s = amt_r - 5'd1;

  // Last bit shifted out, taken from the operand or the finished result.
  always_comb begin
    if ((amt_r == 5'd0) || err_s) begin
      carry_s = 1'b0;
    end else begin
      case (op_r)
        OP_LSL:         carry_s = data_r[amt_inv_s];
        OP_LSR, OP_ASR: carry_s = data_r[idx_lo_s];
        OP_ROL:         carry_s = partial_r[0];
        OP_ROR:         carry_s = partial_r[W-1];
        default:        carry_s = 1'b0;
      endcase
    end
  end
`endif

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= {W{1'b0}};
      out_err   <= 1'b0;
`ifdef SHIFT_CARRY_EN
      out_carry <= 1'b0;
`endif
      op_r      <= 3'd0;
      data_r    <= {W{1'b0}};
      amt_r     <= {AMT_W{1'b0}};
      partial_r <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_r     <= in_op;
            data_r   <= in_data;
            amt_r    <= in_amt;
            in_ready <= 1'b0;
            state_r  <= PASS_A;
          end
        end
        PASS_A: begin
          partial_r <= pass_a_res_s;
          state_r   <= two_pass_s ? PASS_B : DONE;
        end
        PASS_B: begin
          partial_r <= pass_b_res_s;
          state_r   <= DONE;
        end
        DONE: begin
          // First DONE cycle publishes the result; it then holds until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= partial_r;
            out_err   <= err_s;
`ifdef SHIFT_CARRY_EN
            out_carry <= carry_s;
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_op_sequencer.sv
// Directed-vector self-checking bench for shift_op_sequencer (carry checks when SHIFT_CARRY_EN).
module tb_shift_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
`ifdef SHIFT_CARRY_EN
  logic        out_carry;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shift_op_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef SHIFT_CARRY_EN
    .out_carry (out_carry),
`endif
    .out_err   (out_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Presents one request; returns at the negedge following the accept edge.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] d, input logic [4:0] a);
    @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = a;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] d,
                        input logic [4:0] a, input logic [31:0] exp_d, input logic exp_e,
                        input logic exp_c, input int exp_lat);
    issue(tag, op, d, a);
    wait_valid(tag, exp_lat);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_e});
`ifdef SHIFT_CARRY_EN
    check({tag, "_carry"}, {31'd0, out_carry}, {31'd0, exp_c});
`else
    if (exp_c === 1'bx) $display("unexpected carry argument");
`endif
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_data   = 32'd0;
    in_amt    = 5'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data,           32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);
`ifdef SHIFT_CARRY_EN
    check("rst_out_carry", {31'd0, out_carry}, 32'd0);
`endif
    reset = 1'b0;

    //      tag        op     data          amt    expected      err   carry lat
    run_op("lsl1_4",   3'd0, 32'h0000_0001, 5'd4,  32'h0000_0010, 1'b0, 1'b0, 2);
    run_op("lsr_31",   3'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0, 2);
    run_op("asr_neg",  3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0, 3);
    run_op("asr_pos",  3'd2, 32'h7000_0000, 5'd4,  32'h0700_0000, 1'b0, 1'b0, 3);
    run_op("ror_4",    3'd4, 32'h0000_00F1, 5'd4,  32'h1000_000F, 1'b0, 1'b0, 3);
    run_op("rol_1",    3'd3, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 1'b1, 3);
    run_op("rol_0",    3'd3, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0, 2);
    run_op("asr_0",    3'd2, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 1'b0, 2);
    run_op("ror_8",    3'd4, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, 1'b0, 3);
    run_op("rol_4",    3'd3, 32'h1234_5678, 5'd4,  32'h2345_6781, 1'b0, 1'b1, 3);
    run_op("lsl_31",   3'd0, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 1'b1, 2);
    run_op("lsl_c",    3'd0, 32'h8000_0001, 5'd1,  32'h0000_0002, 1'b0, 1'b1, 2);
    run_op("lsr_c",    3'd1, 32'h0000_0002, 5'd2,  32'h0000_0000, 1'b0, 1'b1, 2);
    run_op("ill_7",    3'd7, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 1'b1, 1'b0, 2);

    // Backpressure: result held, new requests ignored while busy.
    issue("bp", 3'd0, 32'h0000_00A5, 5'd1);
    wait_valid("bp", 2);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op    = 3'd1;
      in_data  = 32'hFFFF_0000;
      in_amt   = 5'd7;
      @(negedge clk);
      check("bp_data",  out_data,            32'h0000_014A);
      check("bp_valid", {31'd0, out_valid},  32'd1);
      check("bp_ready", {31'd0, in_ready},   32'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    repeat (3) @(negedge clk);
    check("bp_no_extra", {31'd0, out_valid}, 32'd0);

    // Reset while in PASS_A abandons the operation.
    issue("rmid", 3'd2, 32'h8000_0000, 5'd4);
    reset = 1'b1;
    @(negedge clk);
    check("rmid_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rmid_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rmid_quiet", {31'd0, out_valid}, 32'd0);
    end

    run_op("post_rst", 3'd4, 32'h0000_00F1, 5'd4, 32'h1000_000F, 1'b0, 1'b0, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
